// File: rtl/mem_pkg.sv
// Shared memory-path definitions: access-size encodings, the store-queue entry
// and the byte-lane alignment helper used at store enqueue.
package mem_pkg;

    localparam int MEM_ADDR_W = 32;

    // funct3[1:0] access sizes, also used by the load path
    localparam logic [1:0] FUNC_B = 2'b00;
    localparam logic [1:0] FUNC_H = 2'b01;
    localparam logic [1:0] FUNC_W = 2'b10;

    typedef struct packed {
        logic [MEM_ADDR_W-3:0] waddr;
        logic [31:0]           wdata;
        logic [3:0]            wstrb;
    } store_entry_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        misalign;
    } lane_t;

    // Replicates the right-justified store data across all lanes so the strobe
    // alone selects which bytes land in memory.
    function automatic lane_t lane_align(input logic [1:0]  func,
                                         input logic [1:0]  addr,
                                         input logic [31:0] data);
        lane_t r;
        r = '0;
        case (func)
            FUNC_B: begin
                r.data = {4{data[7:0]}};
                r.strb = 4'b0001 << addr;
            end
            FUNC_H: begin
                r.data     = {2{data[15:0]}};
                r.strb     = addr[1] ? 4'b1100 : 4'b0011;
                r.misalign = addr[0];
            end
            FUNC_W: begin
                r.data     = data;
                r.strb     = 4'b1111;
                r.misalign = (addr != 2'b00);
            end
            default: begin
                r.misalign = 1'b1;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// Core/memory side bundle of the store unit.
// Build option: STORE_FWD_EN adds the ld_addr input used by the load-hazard compare.
interface store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              st_valid;
    logic              st_ready;
    logic [2:0]        st_func;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_wdata;
    logic              st_misalign;

    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-3:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;

    logic              empty;
    logic              ld_hazard;
`ifdef STORE_FWD_EN
    logic [ADDR_W-1:0] ld_addr;

    modport slave (
        input  st_valid, st_func, st_addr, st_wdata, mem_ready, ld_addr,
        output st_ready, st_misalign, mem_we, mem_waddr, mem_wdata, mem_wstrb,
               empty, ld_hazard
    );

    modport master (
        output st_valid, st_func, st_addr, st_wdata, mem_ready, ld_addr,
        input  st_ready, st_misalign, mem_we, mem_waddr, mem_wdata, mem_wstrb,
               empty, ld_hazard
    );
`else
    modport slave (
        input  st_valid, st_func, st_addr, st_wdata, mem_ready,
        output st_ready, st_misalign, mem_we, mem_waddr, mem_wdata, mem_wstrb,
               empty, ld_hazard
    );

    modport master (
        output st_valid, st_func, st_addr, st_wdata, mem_ready,
        input  st_ready, st_misalign, mem_we, mem_waddr, mem_wdata, mem_wstrb,
               empty, ld_hazard
    );
`endif

endinterface

// File: rtl/store_fifo.sv
// In-order store queue. Power-of-two depth so pointers wrap naturally and the
// count MSB doubles as the full flag. Per-entry valid bits and contents are
// exported so the owner can search pending stores.
module store_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  store_entry_t             din,
    output store_entry_t             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DEPTH-1:0]         valid,
    output store_entry_t             entries [DEPTH]
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = count_q[PTR_W];
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_q;
    assign dout    = entries[rd_ptr];

    // Storage, pointers, valid bits and occupancy; reset discards everything pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (do_pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                entries[wr_ptr] <= din;
                valid[wr_ptr]   <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: aligns sb/sh/sw onto byte lanes, rejects misaligned requests,
// queues accepted stores and drains them one per cycle to the word memory.
// mem_* come straight from the queue head, so st_* never reach mem_* combinationally.
// Build option: STORE_FWD_EN enables the load-vs-pending-store hazard compare.
module store_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic         clk,
    input  logic         reset,
    store_unit_if.slave  bus
);

    lane_t                  lane;
    store_entry_t           fifo_din;
    store_entry_t           fifo_head;
    store_entry_t           fifo_entries [DEPTH];
    logic [DEPTH-1:0]       fifo_valid;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   accept;
    logic                   push;
    logic                   pop;
    logic                   misalign_q;
    logic                   unused_func_hi;

    assign lane   = lane_align(bus.st_func[1:0], bus.st_addr[1:0], bus.st_wdata);
    assign accept = bus.st_valid && bus.st_ready;
    assign push   = accept && !lane.misalign;
    assign pop    = bus.mem_we && bus.mem_ready;

    assign fifo_din.waddr = bus.st_addr[ADDR_W-1:2];
    assign fifo_din.wdata = lane.data;
    assign fifo_din.wstrb = lane.strb;

    // funct3[2] only distinguishes signedness on loads
    assign unused_func_hi = bus.st_func[2];

    store_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .din     (fifo_din),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .valid   (fifo_valid),
        .entries (fifo_entries)
    );

    assign bus.st_ready    = !fifo_full;
    assign bus.mem_we      = !fifo_empty;
    assign bus.mem_waddr   = fifo_head.waddr;
    assign bus.mem_wdata   = fifo_head.wdata;
    assign bus.mem_wstrb   = fifo_head.wstrb;
    assign bus.empty       = (fifo_count == '0);
    assign bus.st_misalign = misalign_q;

    // One-cycle reject pulse for a handshaken but misaligned request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= accept && lane.misalign;
        end
    end

`ifdef STORE_FWD_EN
    // Loads are treated as full-word accesses, so any strobe in a matching word counts.
    localparam logic [3:0] LD_MASK = 4'b1111;

    logic ld_hazard_c;
    logic unused_ld_lo;

    assign unused_ld_lo = ^bus.ld_addr[1:0];

    // Flag a load whose word overlaps any store still waiting in the queue.
    always_comb begin
        ld_hazard_c = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i]
                && (fifo_entries[i].waddr == bus.ld_addr[ADDR_W-1:2])
                && ((fifo_entries[i].wstrb & LD_MASK) != 4'b0000)) begin
                ld_hazard_c = 1'b1;
            end
        end
    end

    assign bus.ld_hazard = ld_hazard_c;
`else
    logic [DEPTH-1:0] unused_entry_bits;

    for (genvar i = 0; i < DEPTH; i++) begin : g_unused
        assign unused_entry_bits[i] = ^{fifo_valid[i], fifo_entries[i]};
    end

    assign bus.ld_hazard = 1'b0;
`endif

endmodule
